// File: rtl/capture_sequencer.sv
// Per-channel capture sequencer: pre-trigger fill, armed wait, rising-edge trigger, post capture, frozen display.
// Optional AUTO_TRIGGER_EN adds a timeout that forces a trigger after AUTO_TO armed sample ticks.
`timescale 1ns/1ps
module capture_sequencer #(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DEPTH   = 640,
    parameter int unsigned PRETRIG = 64,
    parameter int unsigned HYST    = 8,
    parameter int unsigned AUTO_TO = 4096
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sample_tick,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [DATA_W-1:0] threshold,
    input  logic              hold,
    input  logic              frame_end,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] start_addr,
    output logic              capture_done,
    output logic              resample,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREFILL = 3'd1,
        ARMED   = 3'd2,
        POST    = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRETRIG - 2);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                arm_q, arm_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
    logic                capture_done_q, capture_done_d;
    logic                resample_q, resample_d;

    logic                do_write;
    logic                level_ge;
    logic                below_band;
    logic                fire;
    logic [ADDR_W-1:0]   ptr_inc;
    logic [ADDR_W-1:0]   start_calc;

    // Re-arm only once the signal has dropped a full hysteresis band below the level.
    assign level_ge   = (sample_in >= threshold);
    assign below_band = (({1'b0, sample_in} + (DATA_W+1)'(HYST)) < {1'b0, threshold});
    assign ptr_inc    = (ptr_q == PTR_LAST) ? '0 : ptr_q + ADDR_W'(1);
    assign start_calc = (ptr_q >= ADDR_W'(PRETRIG)) ? ptr_q - ADDR_W'(PRETRIG)
                                                    : ptr_q + ADDR_W'(DEPTH - PRETRIG);

`ifdef AUTO_TRIGGER_EN
    localparam int unsigned AUTO_W = $clog2(AUTO_TO + 1);

    logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
    logic              auto_hit;

    assign auto_hit = (auto_cnt_q == AUTO_W'(AUTO_TO));
    assign fire     = sample_tick & ((arm_q & level_ge) | auto_hit);

    // Timeout counter runs only while armed, so it restarts on every ARMED entry.
    always_comb begin
        auto_cnt_d = auto_cnt_q;
        if (state_q != ARMED) begin
            auto_cnt_d = '0;
        end else if (sample_tick && !fire) begin
            auto_cnt_d = auto_cnt_q + AUTO_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end
`else
    logic unused_auto_to;

    assign unused_auto_to = (AUTO_TO == 0);
    assign fire           = sample_tick & arm_q & level_ge;
`endif

    // Next-state, write path and output decode.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        cnt_d          = cnt_q;
        arm_d          = 1'b0;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        start_addr_d   = start_addr_q;
        resample_d     = 1'b0;
        do_write       = 1'b0;

        case (state_q)
            IDLE: begin
                state_d    = PREFILL;
                resample_d = 1'b1;
                cnt_d      = '0;
            end
            PREFILL: begin
                if (sample_tick) begin
                    do_write = 1'b1;
                    if (cnt_q == PRE_LAST) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            ARMED: begin
                arm_d = arm_q;
                if (sample_tick) begin
                    do_write = 1'b1;
                    if (fire) begin
                        state_d      = POST;
                        cnt_d        = '0;
                        arm_d        = 1'b0;
                        start_addr_d = start_calc;
                    end else if (below_band) begin
                        arm_d = 1'b1;
                    end
                end
            end
            POST: begin
                if (sample_tick) begin
                    do_write = 1'b1;
                    if (cnt_q == POST_LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                if (frame_end && !hold) begin
                    state_d    = PREFILL;
                    resample_d = 1'b1;
                    cnt_d      = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_write) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = sample_in;
            ptr_d     = ptr_inc;
        end

        capture_done_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            cnt_q          <= '0;
            arm_q          <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            start_addr_q   <= '0;
            capture_done_q <= 1'b0;
            resample_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            arm_q          <= arm_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            start_addr_q   <= start_addr_d;
            capture_done_q <= capture_done_d;
            resample_q     <= resample_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign start_addr   = start_addr_q;
    assign capture_done = capture_done_q;
    assign resample     = resample_q;
    assign state_o      = state_q;

endmodule
